// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle MIPS core
//
// Purpose: sequences fetch/decode/execute for the multicycle datapath that
// shares one unified instruction/data memory. Also counts retired
// instructions and parks in HALT on an unknown opcode.
//
// Ports:
//   Clk       - clock, all state updates on posedge
//   Reset_n   - synchronous active-low reset
//   Opcode    - instruction register [31:26], valid from DECODE onward
//   Zero      - ALU zero flag (same cycle, used for beq)
//   IorD      - memory address select (0 = PC, 1 = ALUOut)
//   MemWrite  - memory write enable
//   IRWrite   - instruction register load
//   PCEn      - PC load (PCWrite | Branch & Zero)
//   PCSrc     - 00 ALUResult, 01 ALUOut, 10 jump target
//   ALUSrcA   - 0 PC, 1 register A
//   ALUSrcB   - 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//   ALUOp     - 00 add, 01 sub, 10 funct
//   RegDst    - 0 rt, 1 rd
//   MemtoReg  - 0 ALUOut, 1 MDR
//   RegWrite  - register file write
//   State     - current state encoding
//   Halted    - high while in HALT
//   Retired   - completed-instruction counter (wraps)

module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2b,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter int         CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCEn,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXECUTE = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_HALT    = 4'd13;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_pcwrite;
  logic             w_branch;

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:    w_next = S_FETCH;
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        if (Opcode == OP_LW || Opcode == OP_SW) w_next = S_MEMADR;
        else if (Opcode == OP_RTYPE)            w_next = S_EXECUTE;
        else if (Opcode == OP_BEQ)              w_next = S_BEQ;
        else if (Opcode == OP_ADDI)             w_next = S_ADDIEX;
        else if (Opcode == OP_J)                w_next = S_JUMP;
        else                                    w_next = S_HALT;
      end
      // Only lw/sw reach MEMADR, so anything that is not lw is treated as sw.
      S_MEMADR:  w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_IDLE;
    endcase
  end

  // The last state of every instruction retires it on its exit edge.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    Halted    = 1'b0;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  // Zero comes straight from the ALU in the BEQ cycle, so this stays combinational.
  assign PCEn    = w_pcwrite | (w_branch & Zero);
  assign State   = r_state;
  assign Retired = r_retired;

endmodule
